// File: rtl/extmem_pkg.sv
// Shared types and defaults for the external memory bus initiator.
package extmem_pkg;

    localparam int unsigned AddrWidth = 13;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned LineWords = 4;
    localparam logic [3:0]  ByteAll   = 4'b1111;

    typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

endpackage

// File: rtl/line_addr_gen.sv
// Beat counter and wrap-within-line word address for one bus transaction.
module line_addr_gen import extmem_pkg::*; #(
    parameter int unsigned AW        = AddrWidth,
    parameter int unsigned LINEWORDS = LineWords
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          load_i,
    input  logic          burst_i,
    input  logic          advance_i,
    input  logic [AW-1:0] start_adr_i,
    output logic [AW-1:0] adr_o,
    output logic          last_o
);

    localparam int unsigned   LW       = $clog2(LINEWORDS);
    localparam logic [LW-1:0] LastBeat = LW'(LINEWORDS - 1);

    logic [AW-1:0] adr_q;
    logic [LW-1:0] beat_q;
    logic          burst_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            adr_q   <= '0;
            beat_q  <= '0;
            burst_q <= 1'b0;
        end else if (load_i) begin
            adr_q   <= start_adr_i;
            beat_q  <= '0;
            burst_q <= burst_i;
        end else if (advance_i) begin
            // Only the in-line offset counts, so the address wraps without carrying upward.
            adr_q[LW-1:0] <= adr_q[LW-1:0] + LW'(1);
            beat_q        <= beat_q + LW'(1);
        end
    end

    assign adr_o  = adr_q;
    assign last_o = !burst_q || (beat_q == LastBeat);

endmodule

// File: rtl/extmem_master.sv
// External memory bus initiator: byte-enabled single writes, single reads and
// critical-word-first line-fill bursts, with a per-beat done timeout.
module extmem_master import extmem_pkg::*; #(
    parameter int unsigned AW        = AddrWidth,
    parameter int unsigned DW        = DataWidth,
    parameter int unsigned LINEWORDS = LineWords,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic          ph1,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_rwb,
    input  logic          req_burst,
    input  logic [AW-1:0] req_adr,
    input  logic [DW-1:0] req_wdata,
    input  logic [3:0]    req_byteen,
    output logic          resp_valid,
    output logic [DW-1:0] resp_data,
    output logic [AW-1:0] resp_adr,
    output logic          resp_last,
    output logic          resp_err,
    output logic [AW-1:0] mem_adr,
    inout  wire  [DW-1:0] mem_data,
    output logic [3:0]    mem_byteen,
    output logic          mem_rwb,
    output logic          mem_en,
    input  logic          mem_done
);

    localparam int unsigned   TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT - 1);

    state_e        state_q;
    logic          mem_en_q, mem_rwb_q, mem_drv_q;
    logic [3:0]    mem_byteen_q;
    logic [DW-1:0] wdata_q;
    logic          resp_valid_q, resp_last_q, resp_err_q;
    logic [DW-1:0] resp_data_q;
    logic [AW-1:0] resp_adr_q;
    logic [TW-1:0] tmo_q;

    logic          accept, tmo_hit, beat_done;
    logic          gen_last, gen_advance, gen_clear;
    logic [AW-1:0] gen_adr;

    assign req_ready   = (state_q == StIdle);
    assign accept      = req_valid && req_ready;
    assign beat_done   = (state_q != StIdle) && mem_done;
    assign tmo_hit     = (state_q != StIdle) && !mem_done && (tmo_q == TmoLast);
    assign gen_advance = (state_q == StRead) && mem_done && !gen_last;
    // Any finished transaction returns the address to its idle value of zero.
    assign gen_clear   = tmo_hit || (beat_done && gen_last);

    line_addr_gen #(
        .AW        (AW),
        .LINEWORDS (LINEWORDS)
    ) u_line_addr_gen (
        .clk_i       (ph1),
        .rst_i       (reset),
        .clear_i     (gen_clear),
        .load_i      (accept),
        .burst_i     (req_burst && req_rwb),
        .advance_i   (gen_advance),
        .start_adr_i (req_adr),
        .adr_o       (gen_adr),
        .last_o      (gen_last)
    );

    always_ff @(posedge ph1) begin
        if (reset) begin
            state_q      <= StIdle;
            mem_en_q     <= 1'b0;
            mem_rwb_q    <= 1'b1;
            mem_drv_q    <= 1'b0;
            mem_byteen_q <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_last_q  <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
            resp_adr_q   <= '0;
            tmo_q        <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_last_q  <= 1'b0;
            resp_err_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q      <= req_rwb ? StRead : StWrite;
                        tmo_q        <= '0;
                        mem_en_q     <= 1'b1;
                        mem_rwb_q    <= req_rwb;
                        mem_drv_q    <= !req_rwb;
                        mem_byteen_q <= req_rwb ? 4'b0000 : req_byteen;
                        wdata_q      <= req_wdata;
                    end
                end
                StRead, StWrite: begin
                    if (mem_done) begin
                        resp_valid_q <= 1'b1;
                        resp_last_q  <= gen_last;
                        resp_adr_q   <= gen_adr;
                        resp_data_q  <= (state_q == StRead) ? mem_data : '0;
                        tmo_q        <= '0;
                    end else if (tmo_hit) begin
                        resp_valid_q <= 1'b1;
                        resp_last_q  <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_adr_q   <= gen_adr;
                        resp_data_q  <= '0;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                    if (gen_clear) begin
                        state_q      <= StIdle;
                        mem_en_q     <= 1'b0;
                        mem_rwb_q    <= 1'b1;
                        mem_drv_q    <= 1'b0;
                        mem_byteen_q <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign mem_data   = mem_drv_q ? wdata_q : 'z;
    assign mem_adr    = gen_adr;
    assign mem_en     = mem_en_q;
    assign mem_rwb    = mem_rwb_q;
    assign mem_byteen = mem_byteen_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_adr   = resp_adr_q;
    assign resp_last  = resp_last_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_extmem_master.sv
// Bench for extmem_master: memory model on the bus, beat/response scoreboard checked
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_extmem_master;
    import extmem_pkg::*;

    localparam int unsigned AW  = AddrWidth;
    localparam int unsigned DW  = DataWidth;
    localparam int unsigned L   = LineWords;
    localparam int unsigned TMO = 8;

    logic          ph1 = 1'b0, reset = 1'b1;
    logic          req_valid = 1'b0, req_rwb = 1'b0, req_burst = 1'b0, mem_done = 1'b0;
    logic [AW-1:0] req_adr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [3:0]    req_byteen = '0;
    logic          req_ready, resp_valid, resp_last, resp_err, mem_rwb, mem_en;
    logic [DW-1:0] resp_data;
    logic [AW-1:0] resp_adr, mem_adr;
    logic [3:0]    mem_byteen;
    wire  [DW-1:0] mem_data;

    extmem_master #(
        .AW        (AW),
        .DW        (DW),
        .LINEWORDS (L),
        .TIMEOUT   (TMO)
    ) dut (
        .ph1        (ph1),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rwb    (req_rwb),
        .req_burst  (req_burst),
        .req_adr    (req_adr),
        .req_wdata  (req_wdata),
        .req_byteen (req_byteen),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_adr   (resp_adr),
        .resp_last  (resp_last),
        .resp_err   (resp_err),
        .mem_adr    (mem_adr),
        .mem_data   (mem_data),
        .mem_byteen (mem_byteen),
        .mem_rwb    (mem_rwb),
        .mem_en     (mem_en),
        .mem_done   (mem_done)
    );

    always #5 ph1 = ~ph1;

    int checks = 0, failures = 0, cyc = 0;
    always @(posedge ph1) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- external memory model ----------------
    logic [DW-1:0] mem      [0:(1<<AW)-1];
    logic          wr_valid [0:(1<<AW)-1];
    logic          mem_clr = 1'b1;
    logic [DW-1:0] wr_word;

    function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
        if (a == 13'h005) return 32'hDEAD_BEEF;
        if (a == 13'h900) return 32'hAABB_CCDD;
        return 32'hC0DE_0000 | DW'(a);
    endfunction

    function automatic logic [DW-1:0] rd_word(input logic [AW-1:0] a);
        return wr_valid[a] ? mem[a] : pattern(a);
    endfunction

    assign mem_data = (mem_en && mem_rwb) ? rd_word(mem_adr) : 'z;

    // The memory writes on every edge with rwb low, whatever en says.
    always @(posedge ph1) begin
        if (mem_clr) begin
            for (int i = 0; i < (1 << AW); i++) wr_valid[i] <= 1'b0;
        end else if (!mem_rwb) begin
            wr_word = rd_word(mem_adr);
            for (int i = 0; i < $bits(ByteAll); i++)
                if (mem_byteen[i]) wr_word[8*i +: 8] = mem_data[8*i +: 8];
            mem[mem_adr]      <= wr_word;
            wr_valid[mem_adr] <= 1'b1;
        end
    end

    // ---------------- transaction model and per-cycle compare ----------------
    typedef struct {
        logic          rd;
        logic [AW-1:0] adr;
        logic [3:0]    be;
        logic [DW-1:0] wdata;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        int            cyc;
        logic [AW-1:0] adr;
        logic [DW-1:0] data;
        logic          last;
        logic          err;
        logic          ready;
    } resp_t;

    beat_t         beatq[$];
    beat_t         pend_b, cur_b;
    logic          pend_v = 1'b0, pend_err = 1'b0;
    int            wait_cnt = 0;
    resp_t         resp_log[$];
    resp_t         rl;
    logic [AW-1:0] en_log[$];
    int            wr_cnt = 0;
    int            acc_cyc = 0;

    always @(negedge ph1) begin
        if (!reset) begin
            if (mem_en) en_log.push_back(mem_adr);
            if (!mem_rwb) wr_cnt++;
            if (resp_valid) begin
                rl.cyc = cyc; rl.adr = resp_adr; rl.data = resp_data;
                rl.last = resp_last; rl.err = resp_err; rl.ready = req_ready;
                resp_log.push_back(rl);
            end
            chk("resp_valid", resp_valid, pend_v);
            if (pend_v && resp_valid) begin
                chk("resp_adr", resp_adr, pend_b.adr);
                chk("resp_data", resp_data, pend_err ? 32'h0 : pend_b.data);
                chk("resp_last", resp_last, pend_err ? 1'b1 : pend_b.last);
                chk("resp_err", resp_err, pend_err);
            end
            pend_v = 1'b0;
            chk("req_ready", req_ready, beatq.size() == 0);
            chk("mem_en", mem_en, beatq.size() != 0);
            if (beatq.size() != 0) begin
                cur_b = beatq[0];
                chk("mem_adr", mem_adr, cur_b.adr);
                chk("mem_rwb", mem_rwb, cur_b.rd);
                chk("mem_byteen", mem_byteen, cur_b.rd ? 4'b0000 : cur_b.be);
                if (!cur_b.rd) chk("mem_wdata", mem_data, cur_b.wdata);
                if (mem_done) begin
                    pend_v = 1'b1; pend_b = cur_b; pend_err = 1'b0;
                    void'(beatq.pop_front());
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                    if (wait_cnt == TMO) begin
                        pend_v = 1'b1; pend_b = cur_b; pend_err = 1'b1;
                        beatq.delete();
                        wait_cnt = 0;
                    end
                end
            end else begin
                chk("idle_mem_rwb", mem_rwb, 1'b1);
                chk("idle_mem_byteen", mem_byteen, 4'b0000);
                chk("idle_mem_adr", mem_adr, '0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge ph1);
        #1;
    endtask

    task automatic clr_logs();
        en_log.delete();
        resp_log.delete();
        wr_cnt = 0;
    endtask

    task automatic issue(input logic rwb, input logic burst, input logic [AW-1:0] adr,
                         input logic [DW-1:0] wd, input logic [3:0] be);
        int            n;
        logic [AW-1:0] a;
        beat_t         b;
        chk("ready_at_issue", req_ready, 1'b1);
        req_valid = 1'b1; req_rwb = rwb; req_burst = burst;
        req_adr = adr; req_wdata = wd; req_byteen = be;
        tick();
        req_valid = 1'b0;
        acc_cyc = cyc;
        n = (rwb && burst) ? L : 1;
        for (int i = 0; i < n; i++) begin
            a = (adr & ~AW'(L - 1)) | AW'((int'(adr) + i) % L);
            b.rd = rwb; b.adr = a; b.be = be; b.wdata = wd;
            b.data = rwb ? rd_word(a) : '0;
            b.last = (i == n - 1);
            beatq.push_back(b);
        end
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while ((beatq.size() != 0 || pend_v) && k < 400) begin
            tick();
            k++;
        end
        chk(name, k < 400, 1'b1);
        tick();
    endtask

    logic [AW-1:0] burst_adr [4] = '{13'h806, 13'h807, 13'h804, 13'h805};
    logic [DW-1:0] burst_dat [4] = '{32'hC0DE_0806, 32'hC0DE_0807, 32'hC0DE_0804, 32'hC0DE_0805};

    initial begin
        repeat (3) tick();
        reset = 1'b0; mem_clr = 1'b0;
        clr_logs();

        // Idle after reset
        repeat (10) tick();
        chk("idle_resp_pulses", resp_log.size(), 0);
        chk("idle_en_cycles", en_log.size(), 0);

        // Single read, done tied high
        mem_done = 1'b1;
        clr_logs();
        issue(1'b1, 1'b0, 13'h005, '0, 4'b0000);
        wait_idle("rd1_bound");
        chk("rd1_en_cycles", en_log.size(), 1);
        chk("rd1_en_adr", en_log[0], 13'h005);
        chk("rd1_resp_count", resp_log.size(), 1);
        chk("rd1_data", resp_log[0].data, 32'hDEAD_BEEF);
        chk("rd1_last", resp_log[0].last, 1'b1);
        chk("rd1_err", resp_log[0].err, 1'b0);
        chk("rd1_latency", resp_log[0].cyc - acc_cyc, 1);

        // Critical-word-first burst
        clr_logs();
        issue(1'b1, 1'b1, 13'h806, '0, 4'b0000);
        wait_idle("burst_bound");
        chk("burst_en_cycles", en_log.size(), 4);
        chk("burst_resp_count", resp_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("burst_en_adr", en_log[i], burst_adr[i]);
            chk("burst_resp_adr", resp_log[i].adr, burst_adr[i]);
            chk("burst_resp_data", resp_log[i].data, burst_dat[i]);
            chk("burst_resp_last", resp_log[i].last, i == 3);
            chk("burst_resp_cycle", resp_log[i].cyc - acc_cyc, 1 + i);
        end

        // Byte-enabled write; burst flag must be ignored
        clr_logs();
        issue(1'b0, 1'b1, 13'h900, 32'h1122_3344, 4'b0101);
        wait_idle("wr_bound");
        chk("wr_rwb_low_cycles", wr_cnt, 1);
        chk("wr_en_cycles", en_log.size(), 1);
        chk("wr_resp_count", resp_log.size(), 1);
        chk("wr_resp_last", resp_log[0].last, 1'b1);
        chk("wr_resp_data", resp_log[0].data, 32'h0);
        chk("wr_mem_word", rd_word(13'h900), 32'hAA22_CC44);

        // Back-to-back single reads: one idle cycle between them
        clr_logs();
        issue(1'b1, 1'b0, 13'h010, '0, 4'b0000);
        begin
            int k = 0;
            while (!req_ready && k < 50) begin tick(); k++; end
            chk("b2b_ready_bound", k < 50, 1'b1);
        end
        issue(1'b1, 1'b0, 13'h011, '0, 4'b0000);
        wait_idle("b2b_bound");
        chk("b2b_resp_count", resp_log.size(), 2);
        chk("b2b_resp_spacing", resp_log[1].cyc - resp_log[0].cyc, 2);
        chk("b2b_second_data", resp_log[1].data, 32'hC0DE_0011);

        // Timeout: done held low on a burst
        mem_done = 1'b0;
        clr_logs();
        issue(1'b1, 1'b1, 13'h040, '0, 4'b0000);
        wait_idle("tmo_bound");
        chk("tmo_en_cycles", en_log.size(), 8);
        chk("tmo_resp_count", resp_log.size(), 1);
        chk("tmo_err", resp_log[0].err, 1'b1);
        chk("tmo_last", resp_log[0].last, 1'b1);
        chk("tmo_adr", resp_log[0].adr, 13'h040);
        chk("tmo_ready", resp_log[0].ready, 1'b1);
        chk("tmo_latency", resp_log[0].cyc - acc_cyc, 8);
        mem_done = 1'b1;

        // Reset during the second beat of a burst drops the transaction
        clr_logs();
        issue(1'b1, 1'b1, 13'h806, '0, 4'b0000);
        tick();
        reset = 1'b1;
        beatq.delete();
        pend_v = 1'b0;
        wait_cnt = 0;
        tick();
        reset = 1'b0;
        clr_logs();
        repeat (3) tick();
        chk("rst_no_resp", resp_log.size(), 0);
        chk("rst_no_en", en_log.size(), 0);
        issue(1'b1, 1'b0, 13'h123, '0, 4'b0000);
        wait_idle("post_rst_bound");
        chk("post_rst_resp_count", resp_log.size(), 1);
        chk("post_rst_data", resp_log[0].data, 32'hC0DE_0123);
        chk("post_rst_last", resp_log[0].last, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
